// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, block type and round-sequencer FSM states.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_NR    = 10;
    localparam int AES_RND_W = 4;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic [2:0] {
        IDLE,
        KEY0,
        ISSUE,
        WAIT,
        DONE
    } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: plaintext/ciphertext handshakes plus the key-schedule and
// round-datapath links of the AES round sequencer. master = sequencer side,
// slave = surrounding key schedule, datapath and block source/sink.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    aes_blk_t             in_block;

    logic                 out_valid;
    logic                 out_ready;
    aes_blk_t             out_block;

    logic                 rk_req_o;
    logic [AES_RND_W-1:0] rk_idx_o;
    logic                 rk_valid_i;
    aes_blk_t             rk_i;

    logic                 dp_start_o;
    aes_blk_t             dp_state_o;
    logic                 dp_last_o;
    aes_blk_t             dp_state_i;

    modport master (
        input  in_valid, in_block, out_ready, rk_valid_i, rk_i, dp_state_i,
        output in_ready, out_valid, out_block, rk_req_o, rk_idx_o,
               dp_start_o, dp_state_o, dp_last_o
    );

    modport slave (
        output in_valid, in_block, out_ready, rk_valid_i, rk_i, dp_state_i,
        input  in_ready, out_valid, out_block, rk_req_o, rk_idx_o,
               dp_start_o, dp_state_o, dp_last_o
    );

endinterface

// File: rtl/aes_rk_fetch.sv
// aes_rk_fetch: round-key request/hold. A request is raised by req_set and
// held until rk_valid_i; the served key is parked in rk_hold until consumed.
module aes_rk_fetch
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_set,
    input  logic [AES_RND_W-1:0] req_idx,
    input  logic                 consume,
    input  logic                 rk_valid_i,
    input  aes_blk_t             rk_i,
    output logic                 rk_req_o,
    output logic [AES_RND_W-1:0] rk_idx_o,
    output logic                 key_avail,
    output aes_blk_t             key_val
);

    logic                 rk_req_q, rk_req_d;
    logic [AES_RND_W-1:0] rk_idx_q, rk_idx_d;
    logic                 rk_got_q, rk_got_d;
    aes_blk_t             rk_hold_q, rk_hold_d;
    logic                 take;

    // A key is only taken while a request is outstanding.
    assign take      = rk_req_q & rk_valid_i;
    assign key_avail = rk_got_q | take;
    assign key_val   = rk_got_q ? rk_hold_q : rk_i;
    assign rk_req_o  = rk_req_q;
    assign rk_idx_o  = rk_idx_q;

    // Capture, then consume, then a fresh request; later assignments take priority.
    always_comb begin
        rk_req_d  = rk_req_q;
        rk_idx_d  = rk_idx_q;
        rk_got_d  = rk_got_q;
        rk_hold_d = rk_hold_q;
        if (take) begin
            rk_req_d  = 1'b0;
            rk_got_d  = 1'b1;
            rk_hold_d = rk_i;
        end
        if (consume) begin
            rk_got_d = 1'b0;
        end
        if (req_set) begin
            rk_req_d = 1'b1;
            rk_idx_d = req_idx;
        end
    end

    // Request and flag registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_req_q <= 1'b0;
            rk_idx_q <= '0;
            rk_got_q <= 1'b0;
        end else begin
            rk_req_q <= rk_req_d;
            rk_idx_q <= rk_idx_d;
            rk_got_q <= rk_got_d;
        end
    end

    // Held key data; only meaningful while rk_got is set.
    always_ff @(posedge clk) begin
        rk_hold_q <= rk_hold_d;
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencer. Whitens the plaintext with key 0,
// drives an external registered round datapath NR times (last round without
// MixColumns) and returns the ciphertext on a valid/ready handshake.
// Optional: define AES_RC_STAT_EN to add the blk_count and busy outputs.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR,
    parameter int DP_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    aes_round_ctrl_if.master bus
`ifdef AES_RC_STAT_EN
    ,
    output logic [31:0] blk_count,
    output logic        busy
`endif
);

    localparam int LAT_W = (DP_LAT < 2) ? 1 : $clog2(DP_LAT + 1);
    localparam logic [AES_RND_W-1:0] LAST_RND = AES_RND_W'(NR);
    localparam logic [LAT_W-1:0]     LAT_INIT = LAT_W'(DP_LAT);

    aes_state_e           state_q, state_d;
    logic [AES_RND_W-1:0] round_q, round_d;
    logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
    logic                 dp_got_q, dp_got_d;
    aes_blk_t             st_q, st_d;
    aes_blk_t             dp_hold_q, dp_hold_d;

    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    aes_blk_t             out_block_q, out_block_d;
    logic                 dp_start_q, dp_start_d;
    aes_blk_t             dp_state_q, dp_state_d;
    logic                 dp_last_q, dp_last_d;

    logic                 accept, key_avail, dp_now, dp_avail, merge, is_last;
    logic                 rk_set, rk_consume;
    aes_blk_t             key_val, dp_val, merged;

    aes_rk_fetch u_rk_fetch (
        .clk        (clk),
        .rst        (rst),
        .req_set    (rk_set),
        .req_idx    (round_d),
        .consume    (rk_consume),
        .rk_valid_i (bus.rk_valid_i),
        .rk_i       (bus.rk_i),
        .rk_req_o   (bus.rk_req_o),
        .rk_idx_o   (bus.rk_idx_o),
        .key_avail  (key_avail),
        .key_val    (key_val)
    );

    // The datapath result is due on the cycle lat_cnt reaches 1; it is taken
    // only once per round and then lives in dp_hold while the key is late.
    assign accept     = (state_q == IDLE) & bus.in_valid & in_ready_q;
    assign is_last    = (round_q == LAST_RND);
    assign dp_now     = (state_q == WAIT) & ~dp_got_q & (lat_cnt_q == LAT_W'(1));
    assign dp_avail   = dp_got_q | dp_now;
    assign dp_val     = dp_got_q ? dp_hold_q : bus.dp_state_i;
    assign merged     = dp_val ^ key_val;
    assign merge      = (state_q == WAIT) & dp_avail & key_avail;
    assign rk_consume = ((state_q == KEY0) & key_avail) | merge;
    assign rk_set     = ((state_d == KEY0) & (state_q != KEY0)) | (state_d == ISSUE);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = KEY0;
            KEY0:    if (key_avail) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (merge) state_d = is_last ? DONE : ISSUE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round state, round counter and datapath-result capture.
    always_comb begin
        st_d      = st_q;
        round_d   = round_q;
        lat_cnt_d = lat_cnt_q;
        dp_got_d  = dp_got_q;
        dp_hold_d = dp_hold_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    st_d    = bus.in_block;
                    round_d = '0;
                end
            end
            KEY0: begin
                if (key_avail) begin
                    st_d    = st_q ^ key_val;
                    round_d = AES_RND_W'(1);
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_INIT;
                dp_got_d  = 1'b0;
            end
            WAIT: begin
                if (lat_cnt_q != '0) lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (merge) begin
                    st_d     = merged;
                    dp_got_d = 1'b0;
                    if (!is_last) round_d = round_q + AES_RND_W'(1);
                end else if (dp_now) begin
                    dp_hold_d = bus.dp_state_i;
                    dp_got_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs decoded from the next state so they line up with it.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        dp_start_d  = (state_d == ISSUE);
        dp_state_d  = (state_d == ISSUE) ? st_d : dp_state_q;
        dp_last_d   = (state_d == ISSUE) ? (round_d == LAST_RND) : dp_last_q;
        out_block_d = (merge && is_last) ? merged : out_block_q;
    end

    // State, control and output registers; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            round_q     <= '0;
            lat_cnt_q   <= '0;
            dp_got_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_block_q <= '0;
            dp_start_q  <= 1'b0;
            dp_state_q  <= '0;
            dp_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            lat_cnt_q   <= lat_cnt_d;
            dp_got_q    <= dp_got_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_block_q <= out_block_d;
            dp_start_q  <= dp_start_d;
            dp_state_q  <= dp_state_d;
            dp_last_q   <= dp_last_d;
        end
    end

    // Working state and held datapath result; gated by the control flags.
    always_ff @(posedge clk) begin
        st_q      <= st_d;
        dp_hold_q <= dp_hold_d;
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_block  = out_block_q;
    assign bus.dp_start_o = dp_start_q;
    assign bus.dp_state_o = dp_state_q;
    assign bus.dp_last_o  = dp_last_q;

`ifdef AES_RC_STAT_EN
    logic [31:0] blk_count_q, blk_count_d;

    // Completed-block counter, one step per output handshake, wrapping at 2^32.
    always_comb begin
        blk_count_d = blk_count_q;
        if (out_valid_q && bus.out_ready) blk_count_d = blk_count_q + 32'd1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) blk_count_q <= '0;
        else     blk_count_q <= blk_count_d;
    end

    assign blk_count = blk_count_q;
    assign busy      = (state_q != IDLE);
`endif

endmodule
